// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared types, constants and helpers for the instruction-fetch stage
package inst_fetch_pkg;

  localparam int          INST_ADDR_W      = 32;
  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // BOOT: first cycle out of reset, RUN: streaming fetch, HOLD: ID stalled, word parked in hold buffer
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } if_state_e;

  // Sequential next PC; 32-bit add wraps silently past 0xFFFF_FFFC
  function automatic logic [INST_ADDR_W-1:0] pc_plus4(input logic [INST_ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_hold_buf.sv
// rtl/inst_hold_buf.sv - one-entry instruction hold buffer with capture, clear and read mux
module inst_hold_buf
  import inst_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [INST_W-1:0] din,
  input  logic [INST_W-1:0] fallback,
  output logic              valid,
  output logic [INST_W-1:0] dout
);

  logic [INST_W-1:0] buf_q;

  // Clear wins over capture so a flush in the same cycle as a stall leaves the buffer empty
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      buf_q <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      buf_q <= din;
    end
  end

  // While parked, the buffered word replaces the live SRAM data
  always_comb begin
    dout = valid ? buf_q : fallback;
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF stage: PC, fetch FSM, redirect/flush handling; optional INST_ADEL_EN adds id_adel
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          DELAY_SLOT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   br_e,
  input  logic [INST_ADDR_W-1:0] br_addr,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [INST_ADDR_W-1:0] inst_sram_addr,
  output logic [INST_W-1:0]      inst_sram_wdata,
  input  logic [INST_W-1:0]      inst_sram_rdata,
  output logic                   id_valid,
  output logic [INST_ADDR_W-1:0] id_pc,
`ifdef INST_ADEL_EN
  output logic                   id_adel,
`endif
  output logic [INST_W-1:0]      id_inst
);

  localparam logic DS_EN = (DELAY_SLOT != 0);

  if_state_e              state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic [INST_ADDR_W-1:0] id_pc_q, id_pc_d;
  logic                   id_valid_q, id_valid_d;
  logic [INST_ADDR_W-1:0] pend_q, pend_d;
  logic                   pend_v_q, pend_v_d;
  logic                   hold_cap, hold_clr, hold_valid;
  logic                   advance, br_take, redirect;
  logic [INST_ADDR_W-1:0] target;
  logic [INST_W-1:0]      live_inst, held_inst;
`ifdef INST_ADEL_EN
  logic                   id_adel_q, id_adel_d;
  logic                   misaligned;
`endif

  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = '0;
  assign inst_sram_addr  = pc_q;

`ifdef INST_ADEL_EN
  assign misaligned   = (pc_q[1:0] != 2'b00);
  assign inst_sram_en = !rst && !(stall && hold_valid) && !misaligned;
  assign id_adel      = id_adel_q;
`else
  assign inst_sram_en = !rst && !(stall && hold_valid);
`endif

  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign live_inst = id_valid_q ? inst_sram_rdata : '0;

  inst_hold_buf u_hold (
    .clk      (clk),
    .rst      (rst),
    .capture  (hold_cap),
    .clear    (hold_clr),
    .din      (inst_sram_rdata),
    .fallback (live_inst),
    .valid    (hold_valid),
    .dout     (held_inst)
  );

  // An address-error fetch is presented to ID as a nop
`ifdef INST_ADEL_EN
  assign id_inst = id_adel_q ? '0 : held_inst;
`else
  assign id_inst = held_inst;
`endif

  // Next-state / next-PC: flush beats redirect beats sequential fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    hold_cap   = 1'b0;
    hold_clr   = 1'b0;
    advance    = 1'b0;
`ifdef INST_ADEL_EN
    id_adel_d  = id_adel_q;
`endif
    br_take    = br_e && id_valid_q;
    redirect   = br_take || pend_v_q;
    target     = br_take ? br_addr : pend_q;

    if (flush) begin
      pc_d       = new_pc;
      id_valid_d = 1'b0;
      hold_clr   = 1'b1;
      pend_v_d   = 1'b0;
      state_d    = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
          advance = !stall;
        end
        ST_RUN: begin
          if (stall) begin
            hold_cap = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            advance = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            advance  = 1'b1;
            hold_clr = 1'b1;
            state_d  = ST_RUN;
          end
        end
        default: state_d = ST_BOOT;
      endcase

      // A branch resolved while ID is stalled waits for the next advance; latest one wins
      if (stall && br_take) begin
        pend_d   = br_addr;
        pend_v_d = 1'b1;
      end

      if (advance) begin
        id_pc_d    = pc_q;
        id_valid_d = !(redirect && !DS_EN);
        pc_d       = redirect ? target : pc_plus4(pc_q);
        pend_v_d   = 1'b0;
`ifdef INST_ADEL_EN
        id_adel_d  = misaligned;
`endif
      end
    end
  end

  // State, PC and IF/ID register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
`ifdef INST_ADEL_EN
      id_adel_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
`ifdef INST_ADEL_EN
      id_adel_q  <= id_adel_d;
`endif
    end
  end

endmodule
